seq_div_32by16: RTL and testbench

- Iterative radix-2 restoring divider: 2*DW-bit dividend / DW-bit divisor -> DW-bit quotient + DW-bit remainder.
- Inverse-direction companion to the 16-bit multiply-accumulate datapath.
- Decomposes accumulated 32-bit MAC results back into quotient/remainder (scaling, averaging).
- Start/done handshake; one quotient bit per cycle.

---
 rtl/seq_div_32by16_pkg.sv | 9 +
 rtl/seq_div_32by16_step.sv | 16 +
 rtl/seq_div_32by16.sv | 74 +++++++
 tb/tb_seq_div_32by16.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/seq_div_32by16_pkg.sv
// div_pkg: shared types and sizing for the sequential restoring divider
package div_pkg;
  localparam int DW_DEF = 16;
  localparam int CNT_W = $clog2(DW_DEF) + 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  function automatic int cnt_w(input int w);
    return $clog2(w) + 1;
  endfunction
endpackage

// File: rtl/seq_div_32by16_step.sv
// div_step: one combinational radix-2 restoring division step on {R,Q}
module div_step #(
  parameter int DW = 16
) (
  input  logic [DW:0]   r,
  input  logic [DW-1:0] q,
  input  logic [DW-1:0] d,
  output logic [DW:0]   r_n,
  output logic [DW-1:0] q_n
);
  logic [DW+1:0] t;
  // r stays below d, so the shifted remainder fits DW+1 bits and t's msb is the borrow
  assign t = {r, q[DW-1]} - {2'b0, d};
  assign r_n = t[DW+1] ? {r[DW-1:0], q[DW-1]} : t[DW:0];
  assign q_n = {q[DW-2:0], ~t[DW+1]};
endmodule

// File: rtl/seq_div_32by16.sv
// seq_div_32by16: iterative 2*DW/DW restoring divider, one quotient bit per cycle
module seq_div_32by16
  import div_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2*DW-1:0] dividend,
  input  logic [DW-1:0]   divisor,
  output logic            busy,
  output logic            done,
  output logic [DW-1:0]   quotient,
  output logic [DW-1:0]   remainder,
  output logic            div_by_zero,
  output logic            overflow
);
  localparam int CW = cnt_w(DW);
  state_t state, state_n;
  logic [DW:0] r, r_n;
  logic [DW-1:0] q, q_n, d;
  logic [CW-1:0] cnt;
  logic acc, dz, ov, last;
  assign acc = start && state != RUN;
  assign dz = divisor == '0;
  assign ov = !dz && dividend[2*DW-1:DW] >= divisor;
  assign last = cnt == CW'(DW - 1);
  div_step #(.DW(DW)) u_step (.r(r), .q(q), .d(d), .r_n(r_n), .q_n(q_n));
  always_comb begin
    state_n = IDLE;
    if (acc) state_n = (dz || ov) ? DONE : RUN;
    else if (state == RUN) state_n = last ? DONE : RUN;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      quotient <= '0;
      remainder <= '0;
      div_by_zero <= 1'b0;
      overflow <= 1'b0;
      r <= '0;
      q <= '0;
      d <= '0;
      cnt <= '0;
    end else begin
      state <= state_n;
      busy <= state_n == RUN;
      done <= state_n == DONE;
      if (acc) begin
        div_by_zero <= dz;
        overflow <= ov;
        if (dz || ov) begin
          quotient <= '1;
          remainder <= dz ? dividend[DW-1:0] : '0;
        end
        r <= {1'b0, dividend[2*DW-1:DW]};
        q <= dividend[DW-1:0];
        d <= divisor;
        cnt <= '0;
      end else if (state == RUN) begin
        r <= r_n;
        q <= q_n;
        cnt <= cnt + CW'(1);
        if (last) begin
          quotient <= q_n;
          remainder <= r_n[DW-1:0];
        end
      end
    end
  end
endmodule

// File: tb/tb_seq_div_32by16.sv
// tb_seq_div_32by16: scoreboard bench for the sequential divider
module tb_seq_div_32by16;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic [31:0] dividend = '0;
  logic [15:0] divisor = '0;
  logic busy, done, div_by_zero, overflow;
  logic [15:0] quotient, remainder;

  seq_div_32by16 dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] q;
    logic [15:0] r;
    logic dbz;
    logic ovf;
    int cyc;
    int bsy;
  } exp_t;

  exp_t sb[$];
  int ncmp = 0;
  int nfail = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // caller must be at a negedge; the following posedge is the accepting edge
  task automatic issue(input logic [31:0] dd, input logic [15:0] dv, input logic [15:0] eq,
                       input logic [15:0] er, input logic edz, input logic eov, input int lat);
    exp_t e;
    start = 1'b1;
    dividend = dd;
    divisor = dv;
    e.q = eq; e.r = er; e.dbz = edz; e.ovf = eov;
    e.cyc = cyc + lat;
    e.bsy = lat - 1;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    dividend = $urandom;
    divisor = 16'($urandom);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 40; i++) begin
      if (sb.size() == 0) return;
      @(negedge clk);
    end
    chk("drain_timeout", 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  task automatic wait_done();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) return;
    end
    chk("done_timeout", 32'(done), 32'd1);
  endtask

  initial begin
    fork
      forever @(posedge clk) cyc++;
      begin : monitor
        int bc;
        exp_t e;
        bc = 0;
        forever begin
          @(negedge clk);
          if (!rst) bc = 0;
          else if (done) begin
            if (sb.size() == 0) chk("spurious_done", 32'(done), 32'd0);
            else begin
              e = sb.pop_front();
              chk("quotient", 32'(quotient), 32'(e.q));
              chk("remainder", 32'(remainder), 32'(e.r));
              chk("div_by_zero", 32'(div_by_zero), 32'(e.dbz));
              chk("overflow", 32'(overflow), 32'(e.ovf));
              chk("latency_cycle", 32'(cyc), 32'(e.cyc));
              chk("busy_cycles", 32'(bc), 32'(e.bsy));
            end
            bc = 0;
          end else if (busy) bc++;
        end
      end
    join_none

    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_quotient", 32'(quotient), 0);
    chk("rst_remainder", 32'(remainder), 0);
    chk("rst_dbz", 32'(div_by_zero), 0);
    chk("rst_ovf", 32'(overflow), 0);
    rst = 1'b1;
    @(negedge clk);

    // basic divide with an ignored mid-run start
    issue(32'd1000, 16'd7, 16'd142, 16'd6, 1'b0, 1'b0, 17);
    repeat (4) @(negedge clk);
    start = 1'b1; dividend = 32'd50; divisor = 16'd5;
    @(negedge clk);
    start = 1'b0;
    wait_drain();

    issue(32'hFFFE0001, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 17);
    wait_drain();
    issue(32'h0000FFFF, 16'h0100, 16'h00FF, 16'h00FF, 1'b0, 1'b0, 17);
    wait_drain();
    issue(32'h12345678, 16'h0000, 16'hFFFF, 16'h5678, 1'b1, 1'b0, 1);
    wait_drain();
    issue(32'h00010000, 16'h0001, 16'hFFFF, 16'h0000, 1'b0, 1'b1, 1);
    wait_drain();
    chk("hold_ovf_idle", 32'(overflow), 32'd1);
    chk("hold_quot_idle", 32'(quotient), 32'hFFFF);

    // back-to-back start in the DONE cycle
    issue(32'd1000, 16'd7, 16'd142, 16'd6, 1'b0, 1'b0, 17);
    wait_done();
    issue(32'd50, 16'd5, 16'd10, 16'd0, 1'b0, 1'b0, 17);
    wait_drain();

    // reset mid-operation aborts with no done pulse
    start = 1'b1; dividend = 32'd1000; divisor = 16'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_quotient", 32'(quotient), 0);
    chk("abort_remainder", 32'(remainder), 0);
    chk("abort_flags", {30'd0, div_by_zero, overflow}, 0);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    issue(32'd100, 16'd3, 16'd33, 16'd1, 1'b0, 1'b0, 17);
    wait_drain();

    for (int i = 0; i < 1000; i++) begin
      logic [15:0] dv, hi;
      logic [31:0] dd;
      dv = 16'($urandom_range(1, 65535));
      hi = 16'($urandom % dv);
      dd = {hi, 16'($urandom)};
      issue(dd, dv, 16'(dd / {16'd0, dv}), 16'(dd % {16'd0, dv}), 1'b0, 1'b0, 17);
      wait_drain();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
